// File: rtl/ft_recovery_unit.sv
// Recovery sequencer: halts both lockstep cores, restores the register file
// (x1..xN) from the safe-memory snapshot, reloads the saved PC, then pulses done.
module ft_recovery_unit #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned HALT_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  recover_i,
  output logic                  core_halt_o,
  input  logic                  core_halted_i,
  output logic [ADDR_WIDTH-1:0] snap_raddr_o,
  input  logic [DATA_WIDTH-1:0] snap_rdata_i,
  input  logic [DATA_WIDTH-1:0] snap_pc_i,
  output logic                  core_we_o,
  output logic [ADDR_WIDTH-1:0] core_waddr_o,
  output logic [DATA_WIDTH-1:0] core_wdata_o,
  output logic                  core_pc_valid_o,
  output logic [DATA_WIDTH-1:0] core_pc_o,
  output logic                  done_o,
  output logic                  abort_o,
  output logic                  busy_o
);

  localparam int unsigned TmoWidth = $clog2(HALT_TIMEOUT) + 1;

  localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = '1;
  localparam logic [TmoWidth-1:0]   TmoLast   = TmoWidth'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StHalt, StRead, StWrite, StPc, StDone} state_e;

  state_e              state;
  logic                rec_q;
  logic [TmoWidth-1:0] tmo_cnt;
  logic                start;

  // Rising edge of the request, honoured only when idle (never queued).
  assign start = recover_i & ~rec_q & (state == StIdle);

  // Snapshot data arrives one cycle after its address, so it is forwarded
  // straight through during the write strobe and forced to 0 otherwise.
  assign core_wdata_o = core_we_o ? snap_rdata_i : '0;

  // Sequencer FSM with registered outputs that line up with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= StIdle;
      rec_q           <= 1'b0;
      tmo_cnt         <= '0;
      core_halt_o     <= 1'b0;
      snap_raddr_o    <= '0;
      core_we_o       <= 1'b0;
      core_waddr_o    <= '0;
      core_pc_valid_o <= 1'b0;
      core_pc_o       <= '0;
      done_o          <= 1'b0;
      abort_o         <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      rec_q           <= recover_i;
      abort_o         <= 1'b0;
      done_o          <= 1'b0;
      core_pc_valid_o <= 1'b0;
      core_pc_o       <= '0;

      unique case (state)
        StIdle: begin
          if (start) begin
            state       <= StHalt;
            core_halt_o <= 1'b1;
            busy_o      <= 1'b1;
            tmo_cnt     <= '0;
          end
        end

        StHalt: begin
          // Halt acknowledge takes priority over a timeout in the same cycle.
          if (core_halted_i) begin
            state        <= StRead;
            snap_raddr_o <= FirstAddr;
          end else if (tmo_cnt == TmoLast) begin
            state       <= StIdle;
            abort_o     <= 1'b1;
            core_halt_o <= 1'b0;
            busy_o      <= 1'b0;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TmoWidth'(1);
          end
        end

        StRead: begin
          state        <= StWrite;
          core_we_o    <= 1'b1;
          core_waddr_o <= snap_raddr_o;
          if (snap_raddr_o != LastAddr) snap_raddr_o <= snap_raddr_o + ADDR_WIDTH'(1);
        end

        StWrite: begin
          if (core_waddr_o == LastAddr) begin
            state           <= StPc;
            core_we_o       <= 1'b0;
            core_waddr_o    <= '0;
            snap_raddr_o    <= '0;
            core_pc_valid_o <= 1'b1;
            core_pc_o       <= snap_pc_i;
          end else begin
            core_we_o    <= 1'b1;
            core_waddr_o <= snap_raddr_o;
            // Saturate so the read address never wraps back to x0.
            if (snap_raddr_o != LastAddr) snap_raddr_o <= snap_raddr_o + ADDR_WIDTH'(1);
          end
        end

        StPc: begin
          state  <= StDone;
          done_o <= 1'b1;
        end

        StDone: begin
          state       <= StIdle;
          core_halt_o <= 1'b0;
          busy_o      <= 1'b0;
        end

        default: begin
          state       <= StIdle;
          core_halt_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
